// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        SIGN = 2'b10
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Core <-> multiply/divide unit bundle: issue, HI/LO writes, reads and stall.
interface muldiv_if import muldiv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             read_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata, read_req,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata, read_req,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_step import muldiv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               div_mode,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem;
    logic [WIDTH:0] diff;

    always_comb begin
        sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff = rem - {1'b0, operand};
        q_bit    = 1'b0;
        acc_next = {sum, acc[WIDTH-1:1]};
        if (div_mode) begin
            // Partial remainder stays below 2*divisor, so diff[WIDTH] is a true sign bit.
            q_bit    = ~diff[WIDTH];
            acc_next = {(q_bit ? diff[WIDTH-1:0] : rem[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative mult/div sequencer owning HI/LO; one bit per cycle, stalls colliding core accesses.
module muldiv_unit import muldiv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               op_signed, op_div;
    logic [2*WIDTH-1:0] step_acc;
    logic               step_q;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_q),
        .operand  (opnd_q),
        .div_mode (is_div_q),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    always_comb begin
        op_signed = op_is_signed(bus.op);
        op_div    = op_is_div(bus.op);
        mag_a     = (op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mag_b     = (op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    is_div_d  = op_div;
                    acc_d     = {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
                    opnd_d    = op_div ? mag_b : mag_a;
                    // Divide by zero must leave the all-ones quotient un-negated.
                    neg_res_d = op_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1])
                                && !(op_div && (bus.b == '0));
                    neg_rem_d = op_signed && bus.a[WIDTH-1];
                end else begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end
            RUN: begin
                acc_d = step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) state_d = SIGN;
            end
            SIGN: begin
                if (is_div_q) begin
                    lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.stall = bus.busy & (bus.read_req | bus.start | bus.hi_we | bus.lo_we);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed table, hand-written corner sequences, random vs arithmetic model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference built from signed/unsigned 64-bit arithmetic on the architectural values.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin u = {32'b0, a} * {32'b0, b}; hi = u[63:32]; lo = u[31:0]; end
            2'b01: begin u = sa * sb; hi = u[63:32]; lo = u[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else if (op == 2'b10) begin
                    lo = a / b;
                    hi = a % b;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                end
            end
        endcase
    endfunction

    // Issues one op, then checks latency, hold-during-run, busy in done cycle and the result.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        logic [31:0] hi0, lo0;
        bit          held;
        int          cyc;
        hi0 = bus.hi;
        lo0 = bus.lo;
        held = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        for (cyc = 1; cyc <= 100; cyc++) begin
            tick();
            if (bus.done) break;
            if (bus.hi !== hi0 || bus.lo !== lo0) held = 1'b0;
        end
        check({name, "_latency"}, 64'(cyc), 64'd33);
        check({name, "_hold"}, 64'(held), 64'd1);
        check({name, "_busy_in_done"}, 64'(bus.busy), 64'd0);
        check({name, "_result"}, {bus.hi, bus.lo}, {ehi, elo});
        $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h (exp %08h %08h) cycles=%0d",
                 op, a, b, bus.hi, bus.lo, ehi, elo, cyc);
    endtask

    initial begin
        logic [31:0] ehi, elo, ra, rb;
        logic [1:0]  rop;
        bit          stall_ok;
        int          cyc;

        total = 0;
        bad = 0;
        vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{2'b10, 32'd10,        32'd0,          32'h0000_000A, 32'hFFFF_FFFF};
        vecs[5]  = '{2'b11, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[6]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[7]  = '{2'b10, 32'd100,       32'd7,          32'h0000_0002, 32'h0000_000E};
        vecs[8]  = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[10] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[11] = '{2'b10, 32'd0,         32'd5,          32'h0000_0000, 32'h0000_0000};

        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.a = '0;
        bus.b = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        bus.read_req = 1'b0;
        reset = 1'b1;
        #2;
        check("reset_state", {bus.hi, bus.lo, 28'd0, bus.busy, bus.done, bus.stall, 1'b0} ,
              {32'd0, 32'd0, 32'd0});
        tick();
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

        // mfhi held from cycle 5, start pulsed at cycle 7 while busy.
        bus.op = OP_MULT;
        bus.a = 32'hFFFF_FFFD;
        bus.b = 32'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        stall_ok = 1'b1;
        for (cyc = 1; cyc <= 100; cyc++) begin
            tick();
            if (bus.done) break;
            if (cyc == 5) bus.read_req = 1'b1;
            bus.start = (cyc == 7);
            if (cyc == 7) begin
                bus.op = OP_MULTU;
                bus.a = 32'd9;
                bus.b = 32'd9;
            end
            #1;
            if (cyc >= 5 && bus.stall !== 1'b1) stall_ok = 1'b0;
        end
        #1;
        check("stall_while_busy", 64'(stall_ok), 64'd1);
        check("stall_done_cycle", 64'(bus.stall), 64'd0);
        check("stall_op_latency", 64'(cyc), 64'd33);
        check("stall_op_result", {bus.hi, bus.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
        bus.read_req = 1'b0;
        tick();
        check("ignored_start_not_run", 64'(bus.busy), 64'd0);
        $display("stall sequence: cycles=%0d hi=%08h lo=%08h", cyc, bus.hi, bus.lo);

        // Asynchronous reset mid-RUN.
        bus.op = OP_DIVU;
        bus.a = 32'd1000;
        bus.b = 32'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        bus.read_req = 1'b1;
        reset = 1'b1;
        #1;
        check("midrun_reset", {bus.hi, bus.lo, 29'd0, bus.busy, bus.done, bus.stall},
              {32'd0, 32'd0, 32'd0});
        bus.read_req = 1'b0;
        #2;
        reset = 1'b0;
        tick();
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_1234;
        tick();
        bus.hi_we = 1'b0;
        check("mthi", {bus.hi, bus.lo}, {32'h0000_1234, 32'd0});
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_5678;
        tick();
        bus.lo_we = 1'b0;
        check("mtlo", {bus.hi, bus.lo}, {32'h0000_1234, 32'h0000_5678});
        $display("reset/mthi/mtlo sequence: hi=%08h lo=%08h", bus.hi, bus.lo);

        // start and mthi together: start wins, hold check inside run_op catches a leaked write.
        bus.hi_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        run_op("start_vs_mthi", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            model(rop, ra, rb, ehi, elo);
            run_op($sformatf("rand%0d", i), rop, ra, rb, ehi, elo);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
